// File: rtl/minx_dbus_target.sv
// MINX data-bus target: 16 x 16-bit register window on a muxed AD bus.
// Address latched on ALE, optional wait states, registered ready.
module minx_dbus_target #(
  parameter logic [15:0] BASE_ADDR   = 16'hF000,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [15:0] dbus_ADBus_i,
  output logic [15:0] dbus_ADBus_o,
  output logic [15:0] dbus_ADBus_oeb,
  input  logic        dbus_ale_i,
  input  logic [1:0]  dbus_stb_i,
  input  logic        dbus_rd_i,
  input  logic        dbus_wr_i,
  output logic        dbus_rdy_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WAIT,
    S_RESP,
    S_HOLD
  } state_t;

  localparam logic [3:0] LP_CNT0 =
    (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  state_t      r_state;
  state_t      w_nxt;
  logic [15:1] r_addr;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_d;
  logic        r_rdy;
  logic        w_rdy_d;
  logic        r_drv;
  logic        w_drv_d;
  logic        r_isrd;
  logic        w_isrd_d;
  logic [15:0] r_dout;
  logic [15:0] w_dout_d;
  logic        w_we;
  logic        w_hit;
  logic        w_drop;
  logic [15:0] r_mem [16];

  assign w_hit  = (r_addr[15:5] == BASE_ADDR[15:5]);
  assign w_drop = r_isrd ? !dbus_rd_i : !dbus_wr_i;

  always_comb begin
    w_nxt    = r_state;
    w_cnt_d  = r_cnt;
    w_rdy_d  = 1'b0;
    w_drv_d  = r_drv;
    w_isrd_d = r_isrd;
    w_dout_d = r_dout;
    w_we     = 1'b0;
    if (dbus_ale_i) begin
      w_nxt   = S_ADDR;
      w_drv_d = 1'b0;
      w_cnt_d = '0;
    end else begin
      unique case (r_state)
        S_IDLE: ;
        S_ADDR: begin
          if (!w_hit) begin
            w_nxt = S_IDLE;
          end else if (dbus_rd_i && dbus_wr_i) begin
            w_nxt = S_HOLD;
          end else if (dbus_rd_i || dbus_wr_i) begin
            w_isrd_d = dbus_rd_i;
            w_drv_d  = dbus_rd_i;
            w_dout_d = r_mem[r_addr[4:1]];
            if (WAIT_STATES == 0) begin
              w_nxt   = S_RESP;
              w_rdy_d = 1'b1;
            end else begin
              w_nxt   = S_WAIT;
              w_cnt_d = LP_CNT0;
            end
          end
        end
        S_WAIT: begin
          if (w_drop) begin
            w_nxt   = S_IDLE;
            w_drv_d = 1'b0;
            w_cnt_d = '0;
          end else if (r_cnt == '0) begin
            w_nxt   = S_RESP;
            w_rdy_d = 1'b1;
          end else begin
            w_cnt_d = r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          w_nxt = S_HOLD;
          w_we  = !r_isrd;
          if (!dbus_rd_i) w_drv_d = 1'b0;
        end
        S_HOLD: begin
          if (!dbus_rd_i) w_drv_d = 1'b0;
          if (!dbus_rd_i && !dbus_wr_i) w_nxt = S_IDLE;
        end
        default: w_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_cnt   <= '0;
      r_rdy   <= 1'b0;
      r_drv   <= 1'b0;
      r_isrd  <= 1'b0;
      r_dout  <= '0;
    end else begin
      r_state <= w_nxt;
      r_cnt   <= w_cnt_d;
      r_rdy   <= w_rdy_d;
      r_drv   <= w_drv_d;
      r_isrd  <= w_isrd_d;
      r_dout  <= w_dout_d;
      if (dbus_ale_i) r_addr <= dbus_ADBus_i[15:1];
    end
  end

  // Byte-masked write at the edge closing the ready cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 16; i++) r_mem[i] <= '0;
    end else if (w_we) begin
      if (dbus_stb_i[0])
        r_mem[r_addr[4:1]][7:0] <= dbus_ADBus_i[7:0];
      if (dbus_stb_i[1])
        r_mem[r_addr[4:1]][15:8] <= dbus_ADBus_i[15:8];
    end
  end

  assign dbus_rdy_o     = r_rdy;
  assign dbus_ADBus_o   = r_drv ? r_dout : 16'h0000;
  assign dbus_ADBus_oeb = {16{~r_drv}};

endmodule
